// File: rtl/mio_bus_slave.sv
// MIO responder: accepts qualified CPU requests and routes them to block RAM or the peripheral port.
// Define MIO_TIMEOUT_EN to add a peripheral ack timeout that completes with bus_err and 32'hDEAD_BEEF.
module mio_bus_slave #(
  parameter int unsigned RAM_WAIT   = 2,
  parameter int unsigned RAM_AW     = 12,
  parameter logic [3:0]  IO_PREFIX  = 4'hE,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_mio,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [1:0]        data_sel,
  input  logic [31:0]       wdata,
  output logic              mio_ready,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              io_rd,
  output logic              io_wr,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_din,
  output logic [3:0]        io_be,
  input  logic [31:0]       io_dout,
  input  logic              io_ack,
  output logic              bus_err
);

  localparam int unsigned CntMax = (RAM_WAIT > IO_TIMEOUT) ? RAM_WAIT : IO_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StRamWait, StIoWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              wr_q;
  logic [31:0]       addr_q, din_q, rdata_q;
  logic [3:0]        be_q, ram_we_q;
  logic              ram_en_q, io_rd_q, io_wr_q, bus_err_q;
  logic              req, is_io, timeout;
  logic [3:0]        be;
  logic [31:0]       din_rep;

  assign req   = cpu_mio & (mem_r | mem_w);
  assign is_io = addr[31:28] >= IO_PREFIX;

`ifdef MIO_TIMEOUT_EN
  assign timeout = (state_q == StIoWait) && !io_ack && (cnt_q == CntW'(IO_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Lane enables and lane-replicated store data from the live request.
  always_comb begin
    be      = 4'b1111;
    din_rep = wdata;
    unique case (data_sel)
      2'b01: begin
        be      = 4'b0001 << addr[1:0];
        din_rep = {4{wdata[7:0]}};
      end
      2'b10: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        din_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req) state_d = is_io ? StIoWait : StRamWait;
      StRamWait: if (cnt_q == '0) state_d = StDone;
      StIoWait:  if (io_ack || timeout) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= '0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      ram_we_q  <= '0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            wr_q   <= mem_w;
            addr_q <= addr;
            din_q  <= din_rep;
            be_q   <= be;
            if (is_io) begin
              io_rd_q <= ~mem_w;
              io_wr_q <= mem_w;
              cnt_q   <= '0;
            end else begin
              ram_en_q <= 1'b1;
              ram_we_q <= mem_w ? be : 4'b0000;
              cnt_q    <= CntW'(RAM_WAIT - 1);
            end
          end
        end
        StRamWait: begin
          if (cnt_q == '0) begin
            ram_en_q <= 1'b0;
            if (!wr_q) rdata_q <= ram_dout;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StIoWait: begin
          if (io_ack) begin
            io_rd_q <= 1'b0;
            io_wr_q <= 1'b0;
            if (!wr_q) rdata_q <= io_dout;
          end else if (timeout) begin
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            rdata_q   <= 32'hDEAD_BEEF;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is combinational on req in idle so the controller never advances in the request cycle.
  always_comb begin
    mio_ready = ((state_q == StIdle) && !req) || (state_q == StDone);
  end

  assign rdata    = rdata_q;
  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = addr_q[RAM_AW+1:2];
  assign ram_din  = din_q;
  assign io_rd    = io_rd_q;
  assign io_wr    = io_wr_q;
  assign io_addr  = addr_q;
  assign io_din   = din_q;
  assign io_be    = be_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mio_bus_slave.sv
// Self-checking bench for mio_bus_slave: directed vectors plus randomized RAM/IO traffic
// checked against a byte-level memory model and transaction latency rules.
module tb_mio_bus_slave;
  localparam int unsigned RamWait   = 2;
  localparam int unsigned RamAw     = 12;
  localparam int unsigned IoTimeout = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_mio, mem_r, mem_w;
  logic [31:0]       addr, wdata;
  logic [1:0]        data_sel;
  logic              mio_ready;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RamAw-1:0]  ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout = 32'h0;
  logic              io_rd, io_wr;
  logic [31:0]       io_addr, io_din, io_dout;
  logic [3:0]        io_be;
  logic              io_ack;
  logic              bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'h0;

  logic [31:0] env_mem [0:(1<<RamAw)-1];
  logic [31:0] ref_mem [0:(1<<RamAw)-1];

  always #5 clk = ~clk;

  mio_bus_slave #(
    .RAM_WAIT(RamWait), .RAM_AW(RamAw), .IO_PREFIX(4'hE), .IO_TIMEOUT(IoTimeout)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_mio(cpu_mio), .mem_r(mem_r), .mem_w(mem_w),
    .addr(addr), .data_sel(data_sel), .wdata(wdata), .mio_ready(mio_ready), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_din(io_din),
    .io_be(io_be), .io_dout(io_dout), .io_ack(io_ack), .bus_err(bus_err)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Synchronous block RAM: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout          <= env_mem[ram_addr];
      env_mem[ram_addr] <= merge(env_mem[ram_addr], ram_din, ram_we);
    end
  end

  function automatic int size_of(input logic [1:0] sel);
    if (sel == 2'b01) return 1;
    if (sel == 2'b10) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sel, input logic [31:0] a);
    int sz, off, m;
    sz  = size_of(sel);
    off = ((int'(a % 4)) / sz) * sz;
    m   = ((1 << sz) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_din(input logic [1:0] sel, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = size_of(sel);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  task automatic ram_txn(input logic w, input logic r, input logic [31:0] a,
                         input logic [1:0] sel, input logic [31:0] wd, output int lat,
                         output logic [3:0] we1, output logic [31:0] din1,
                         output logic [RamAw-1:0] addr1, output logic en1);
    lat = -1; we1 = '0; din1 = '0; addr1 = '0; en1 = 1'b0;
    cpu_mio = 1'b1; mem_w = w; mem_r = r; addr = a; data_sel = sel; wdata = wd;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin addr = $urandom; wdata = $urandom; end
      #1;
      if (k == 1) begin we1 = ram_we; din1 = ram_din; addr1 = ram_addr; en1 = ram_en; end
      if (mio_ready) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
  endtask

  task automatic io_txn(input logic w, input logic [31:0] a, input logic [1:0] sel,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] dout,
                        input int bound, output int lat, output int strobes, output int errs,
                        output logic err_at_ready, output logic [31:0] addr1,
                        output logic [31:0] din1, output logic [3:0] be1,
                        output logic rd1, output logic wr1);
    lat = -1; strobes = 0; errs = 0; err_at_ready = 1'b0;
    addr1 = '0; din1 = '0; be1 = '0; rd1 = 1'b0; wr1 = 1'b0;
    cpu_mio = 1'b1; mem_w = w; mem_r = ~w; addr = a; data_sel = sel; wdata = wd;
    for (int k = 0; k < bound; k++) begin
      if (k > 0) begin addr = $urandom; wdata = $urandom; end
      io_ack  = (k == ack_at);
      io_dout = io_ack ? dout : $urandom;
      #1;
      if (k == 1) begin addr1 = io_addr; din1 = io_din; be1 = io_be; rd1 = io_rd; wr1 = io_wr; end
      if (io_rd || io_wr) strobes++;
      if (bus_err) errs++;
      if (mio_ready) begin lat = k; err_at_ready = bus_err; break; end
      @(posedge clk); #1;
    end
    io_ack = 1'b0;
    @(posedge clk); #1;
    cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (mio_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", mio_ready); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    n_tests++; if (ram_we !== 4'h0 || ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram got en=%b we=%b want 0", ram_en, ram_we); end
    n_tests++; if (io_rd !== 1'b0 || io_wr !== 1'b0) begin n_fail++; $display("FAIL reset_io got rd=%b wr=%b want 0", io_rd, io_wr); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int lat, strobes, errs;
    logic [3:0] we1, be1;
    logic [31:0] din1, a1;
    logic [RamAw-1:0] ra1;
    logic en1, eready, rd1, wr1;
    env_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    ram_txn(1'b0, 1'b1, 32'h10, 2'b00, 32'h0, lat, we1, din1, ra1, en1);
    n_tests++; if (lat != RamWait + 1) begin n_fail++; $display("FAIL v1_latency got %0d want %0d", lat, RamWait + 1); end
    n_tests++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL v1_rdata got %h want 12345678", rdata); end
    exp_rdata = 32'h1234_5678;
    ram_txn(1'b1, 1'b0, 32'h13, 2'b01, 32'hA5, lat, we1, din1, ra1, en1);
    n_tests++; if (we1 !== 4'b1000) begin n_fail++; $display("FAIL v2_we got %b want 1000", we1); end
    n_tests++; if (din1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL v2_din got %h want a5a5a5a5", din1); end
    n_tests++; if (ra1 !== RamAw'(4)) begin n_fail++; $display("FAIL v2_addr got %0d want 4", ra1); end
    n_tests++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL v2_rdata_kept got %h want %h", rdata, exp_rdata); end
    ref_mem[4] = 32'hA534_5678;
    ram_txn(1'b1, 1'b0, 32'h22, 2'b10, 32'hBEEF, lat, we1, din1, ra1, en1);
    n_tests++; if (we1 !== 4'b1100) begin n_fail++; $display("FAIL v3_we got %b want 1100", we1); end
    n_tests++; if (din1 !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL v3_din got %h want beefbeef", din1); end
    ref_mem[8] = {16'hBEEF, ref_mem[8][15:0]};
    ram_txn(1'b0, 1'b1, 32'h10, 2'b00, 32'h0, lat, we1, din1, ra1, en1);
    n_tests++; if (rdata !== 32'hA534_5678) begin n_fail++; $display("FAIL v2_readback got %h want a5345678", rdata); end
    io_txn(1'b0, 32'hE000_0004, 2'b00, 32'h0, 5, 32'h0000_CAFE, 40,
           lat, strobes, errs, eready, a1, din1, be1, rd1, wr1);
    n_tests++; if (strobes != 5) begin n_fail++; $display("FAIL v4_io_rd_cycles got %0d want 5", strobes); end
    n_tests++; if (lat != 6) begin n_fail++; $display("FAIL v4_latency got %0d want 6", lat); end
    n_tests++; if (rdata !== 32'h0000_CAFE) begin n_fail++; $display("FAIL v4_rdata got %h want 0000cafe", rdata); end
    n_tests++; if (a1 !== 32'hE000_0004 || rd1 !== 1'b1 || wr1 !== 1'b0) begin n_fail++; $display("FAIL v4_io_addr got %h rd=%b wr=%b want e0000004 rd=1 wr=0", a1, rd1, wr1); end
    exp_rdata = 32'h0000_CAFE;
  endtask

  task automatic test_rw_priority_and_reset();
    int lat;
    logic [3:0] we1;
    logic [31:0] din1, old;
    logic [RamAw-1:0] ra1;
    logic en1;
    ram_txn(1'b1, 1'b1, 32'h40, 2'b00, 32'h0BAD_F00D, lat, we1, din1, ra1, en1);
    n_tests++; if (we1 !== 4'b1111) begin n_fail++; $display("FAIL both_rw_we got %b want 1111", we1); end
    n_tests++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL both_rw_rdata got %h want %h", rdata, exp_rdata); end
    ref_mem[16] = 32'h0BAD_F00D;
    // Reset lands during the cycle the write strobe is up, so the write must never reach RAM.
    old = ref_mem[20];
    cpu_mio = 1'b1; mem_w = 1'b1; mem_r = 1'b0; addr = 32'h50; data_sel = 2'b00; wdata = ~old;
    @(posedge clk); #1;
    n_tests++; if (ram_we !== 4'b1111) begin n_fail++; $display("FAIL mid_we_before_reset got %b want 1111", ram_we); end
    reset_n = 1'b0; cpu_mio = 1'b0; mem_w = 1'b0;
    #1;
    n_tests++; if (ram_we !== 4'h0 || ram_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ram got en=%b we=%b want 0", ram_en, ram_we); end
    n_tests++; if (mio_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b want 1", mio_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    exp_rdata = 32'h0;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata got %h want 0", rdata); end
    ram_txn(1'b0, 1'b1, 32'h50, 2'b00, 32'h0, lat, we1, din1, ra1, en1);
    n_tests++; if (rdata !== old) begin n_fail++; $display("FAIL mid_reset_no_write got %h want %h", rdata, old); end
    exp_rdata = old;
  endtask

  task automatic test_random();
    int lat, strobes, errs, kind, widx, ack_at;
    logic [3:0] we1, be1, ebe;
    logic [31:0] din1, a1, a, wd, dout, edin;
    logic [RamAw-1:0] ra1;
    logic [1:0] sel;
    logic en1, eready, rd1, wr1, w;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      sel  = 2'($urandom_range(0, 3));
      wd   = $urandom;
      w    = (kind == 1 || kind == 3);
      ebe  = exp_be(sel, 32'($urandom_range(0, 3)));
      if (kind < 2) begin
        widx = $urandom_range(0, 15);
        a = ($urandom & 32'h0FFF_C000) | (32'($urandom_range(0, 13)) << 28) | 32'(widx << 2)
            | 32'($urandom_range(0, 3));
        ebe  = exp_be(sel, a);
        edin = exp_din(sel, wd);
        ram_txn(w, w ? 1'($urandom_range(0, 1)) : 1'b1, a, sel, wd, lat, we1, din1, ra1, en1);
        n_tests++; if (lat != RamWait + 1) begin n_fail++; $display("FAIL rnd_ram_latency it=%0d got %0d want %0d", it, lat, RamWait + 1); end
        n_tests++; if (ra1 !== RamAw'(widx) || en1 !== 1'b1) begin n_fail++; $display("FAIL rnd_ram_addr it=%0d got %0d en=%b want %0d en=1", it, ra1, en1, widx); end
        if (w) begin
          n_tests++; if (we1 !== ebe || din1 !== edin) begin n_fail++; $display("FAIL rnd_ram_write it=%0d got we=%b din=%h want we=%b din=%h", it, we1, din1, ebe, edin); end
          ref_mem[widx] = merge(ref_mem[widx], edin, ebe);
        end else begin
          n_tests++; if (we1 !== 4'h0) begin n_fail++; $display("FAIL rnd_ram_read_we it=%0d got %b want 0000", it, we1); end
          exp_rdata = ref_mem[widx];
        end
      end else begin
        a      = {3'b111, 1'($urandom_range(0, 1)), 28'($urandom)};
        ack_at = $urandom_range(1, 6);
        dout   = $urandom;
        ebe    = exp_be(sel, a);
        edin   = exp_din(sel, wd);
        io_txn(w, a, sel, wd, ack_at, dout, 40, lat, strobes, errs, eready, a1, din1, be1, rd1, wr1);
        n_tests++; if (lat != ack_at + 1 || strobes != ack_at) begin n_fail++; $display("FAIL rnd_io_timing it=%0d got lat=%0d strobes=%0d want lat=%0d strobes=%0d", it, lat, strobes, ack_at + 1, ack_at); end
        n_tests++; if (a1 !== a || be1 !== ebe || rd1 !== !w || wr1 !== w) begin n_fail++; $display("FAIL rnd_io_req it=%0d got a=%h be=%b rd=%b wr=%b want a=%h be=%b rd=%b wr=%b", it, a1, be1, rd1, wr1, a, ebe, !w, w); end
        if (w) begin
          n_tests++; if (din1 !== edin) begin n_fail++; $display("FAIL rnd_io_din it=%0d got %h want %h", it, din1, edin); end
        end else begin
          exp_rdata = dout;
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL rnd_io_bus_err it=%0d got %0d pulses want 0", it, errs); end
      end
      n_tests++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata it=%0d got %h want %h", it, rdata, exp_rdata); end
    end
  endtask

  task automatic test_timeout();
    int lat, strobes, errs;
    logic [3:0] be1;
    logic [31:0] din1, a1;
    logic eready, rd1, wr1;
`ifdef MIO_TIMEOUT_EN
    io_txn(1'b0, 32'hE000_0010, 2'b00, 32'h0, -1, 32'h0, 40,
           lat, strobes, errs, eready, a1, din1, be1, rd1, wr1);
    n_tests++; if (lat != int'(IoTimeout) + 1 || strobes != int'(IoTimeout)) begin n_fail++; $display("FAIL timeout_timing got lat=%0d strobes=%0d want lat=%0d strobes=%0d", lat, strobes, IoTimeout + 1, IoTimeout); end
    n_tests++; if (errs != 1 || eready !== 1'b1) begin n_fail++; $display("FAIL timeout_bus_err got pulses=%0d at_ready=%b want 1 1", errs, eready); end
    n_tests++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_rdata got %h want deadbeef", rdata); end
    n_tests++; if (bus_err !== 1'b0 || mio_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_after got err=%b ready=%b want 0 1", bus_err, mio_ready); end
`else
    io_txn(1'b0, 32'hE000_0010, 2'b00, 32'h0, -1, 32'h0, 101,
           lat, strobes, errs, eready, a1, din1, be1, rd1, wr1);
    n_tests++; if (lat != -1) begin n_fail++; $display("FAIL no_timeout_ready got ready at cycle %0d want none in 100", lat); end
    n_tests++; if (errs != 0 || io_rd !== 1'b1) begin n_fail++; $display("FAIL no_timeout_strobe got err=%0d io_rd=%b want 0 1", errs, io_rd); end
    reset_n = 1'b0;
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (mio_ready !== 1'b1 || io_rd !== 1'b0) begin n_fail++; $display("FAIL no_timeout_recover got ready=%b io_rd=%b want 1 0", mio_ready, io_rd); end
`endif
  endtask

  initial begin
    reset_n = 1'b0; cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0; addr = '0; data_sel = '0;
    wdata = '0; io_ack = 1'b0; io_dout = '0;
    for (int i = 0; i < (1 << RamAw); i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    test_reset();
    test_vectors();
    test_rw_priority_and_reset();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
